// File: rtl/ex_unit.sv
// SimpleRISC execute stage: single-cycle ALU/branch ops plus a 32-step iterative mul/div/mod engine.
// Define EX_FAST_MUL_EN to move mul onto a combinational multiplier and the single-cycle path.
//
// state  | meaning
// IDLE   | waiting for start; busy=0
// ITER   | one radix-2 mul/div step per cycle, count 0..31
// FIN    | outputs already written; done=1 for this one cycle
module ex_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [5:0]  opcode_and_I,
  input  logic [31:0] op1,
  input  logic [31:0] op2,
  input  logic [31:0] immx,
  input  logic [31:0] branchTarget,
  output logic        busy,
  output logic        done,
  output logic [31:0] aluResult,
  output logic        flagE,
  output logic        flagGT,
  output logic        isBranchTaken,
  output logic [31:0] branchPC
);

  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_SUB  = 5'b00001;
  localparam logic [4:0] OP_MUL  = 5'b00010;
  localparam logic [4:0] OP_DIV  = 5'b00011;
  localparam logic [4:0] OP_MOD  = 5'b00100;
  localparam logic [4:0] OP_CMP  = 5'b00101;
  localparam logic [4:0] OP_AND  = 5'b00110;
  localparam logic [4:0] OP_OR   = 5'b00111;
  localparam logic [4:0] OP_NOT  = 5'b01000;
  localparam logic [4:0] OP_MOV  = 5'b01001;
  localparam logic [4:0] OP_LSL  = 5'b01010;
  localparam logic [4:0] OP_LSR  = 5'b01011;
  localparam logic [4:0] OP_ASR  = 5'b01100;
  localparam logic [4:0] OP_LD   = 5'b01110;
  localparam logic [4:0] OP_ST   = 5'b01111;
  localparam logic [4:0] OP_BEQ  = 5'b10000;
  localparam logic [4:0] OP_BGT  = 5'b10001;
  localparam logic [4:0] OP_B    = 5'b10010;
  localparam logic [4:0] OP_CALL = 5'b10011;
  localparam logic [4:0] OP_RET  = 5'b10100;

  typedef enum logic [1:0] {S_IDLE, S_ITER, S_FIN} state_t;

  state_t      state, state_nxt;
  logic        accept;
  logic        iter_in;
  logic [4:0]  op_in;
  logic [31:0] b_in;
  logic [31:0] abs_a, abs_b;
  logic [31:0] single_res;
  logic        taken_in;

  logic [4:0]  lat_op;
  logic [31:0] lat_a;
  logic [31:0] lat_bt;
  logic        lat_sa, lat_sb, lat_bz;
  logic [4:0]  count;
  logic [31:0] it_acc, it_a, it_b;
  logic [31:0] step_acc, step_a, step_b;
  logic [32:0] shifted;
  logic        ge;
  logic [31:0] iter_res;

  assign op_in = opcode_and_I[5:1];
  assign b_in  = opcode_and_I[0] ? immx : op2;
  assign abs_a = op1[31]  ? -op1  : op1;
  assign abs_b = b_in[31] ? -b_in : b_in;

`ifdef EX_FAST_MUL_EN
  assign iter_in = (op_in == OP_DIV) || (op_in == OP_MOD);
`else
  assign iter_in = (op_in == OP_MUL) || (op_in == OP_DIV) || (op_in == OP_MOD);
`endif

  assign busy = (state != S_IDLE);
  assign done = (state == S_FIN);

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = iter_in ? S_ITER : S_FIN;
        end
      end
      S_ITER:  if (count == 5'd31) state_nxt = S_FIN;
      S_FIN:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    single_res = '0;
    case (op_in)
      OP_ADD, OP_LD, OP_ST: single_res = op1 + b_in;
      OP_SUB:  single_res = op1 - b_in;
      OP_AND:  single_res = op1 & b_in;
      OP_OR:   single_res = op1 | b_in;
      OP_NOT:  single_res = ~b_in;
      OP_MOV:  single_res = b_in;
      OP_LSL:  single_res = op1 << b_in[4:0];
      OP_LSR:  single_res = op1 >> b_in[4:0];
      OP_ASR:  single_res = $unsigned($signed(op1) >>> b_in[4:0]);
`ifdef EX_FAST_MUL_EN
      OP_MUL:  single_res = op1 * b_in;
`endif
      default: single_res = '0;
    endcase
  end

  always_comb begin
    taken_in = 1'b0;
    case (op_in)
      OP_B, OP_CALL, OP_RET: taken_in = 1'b1;
      OP_BEQ:  taken_in = flagE;
      OP_BGT:  taken_in = flagGT;
      default: taken_in = 1'b0;
    endcase
  end

  // mul: it_a = shifted multiplicand, it_b = multiplier. div/mod: it_acc = remainder,
  // it_a = dividend shifting out / quotient shifting in, it_b = divisor.
  assign shifted = {it_acc, it_a[31]};
  assign ge      = (shifted >= {1'b0, it_b});

  always_comb begin
    step_acc = it_acc;
    step_a   = it_a;
    step_b   = it_b;
    if (lat_op == OP_MUL) begin
      step_acc = it_b[0] ? (it_acc + it_a) : it_acc;
      step_a   = it_a << 1;
      step_b   = it_b >> 1;
    end else begin
      step_acc = ge ? (shifted[31:0] - it_b) : shifted[31:0];
      step_a   = {it_a[30:0], ge};
    end
  end

  always_comb begin
    iter_res = '0;
    case (lat_op)
      OP_MUL:  iter_res = (lat_sa ^ lat_sb) ? -step_acc : step_acc;
      OP_DIV:  iter_res = lat_bz ? 32'd0 : ((lat_sa ^ lat_sb) ? -step_a : step_a);
      OP_MOD:  iter_res = lat_bz ? lat_a : (lat_sa ? -step_acc : step_acc);
      default: iter_res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      aluResult     <= '0;
      flagE         <= 1'b0;
      flagGT        <= 1'b0;
      isBranchTaken <= 1'b0;
      branchPC      <= '0;
      lat_op        <= '0;
      lat_a         <= '0;
      lat_bt        <= '0;
      lat_sa        <= 1'b0;
      lat_sb        <= 1'b0;
      lat_bz        <= 1'b0;
      count         <= '0;
      it_acc        <= '0;
      it_a          <= '0;
      it_b          <= '0;
    end else begin
      if (accept) begin
        lat_op <= op_in;
        lat_a  <= op1;
        lat_bt <= branchTarget;
        lat_sa <= op1[31];
        lat_sb <= b_in[31];
        lat_bz <= (b_in == 32'd0);
        it_acc <= '0;
        it_a   <= abs_a;
        it_b   <= abs_b;
        count  <= '0;
        // Single-cycle ops are written on the accept edge so they are valid in the FIN cycle.
        if (!iter_in) begin
          aluResult     <= single_res;
          isBranchTaken <= taken_in;
          branchPC      <= (op_in == OP_RET) ? op1 : branchTarget;
          if (op_in == OP_CMP) begin
            flagE  <= (op1 == b_in);
            flagGT <= ($signed(op1) > $signed(b_in));
          end
        end
      end
      if (state == S_ITER) begin
        count  <= count + 5'd1;
        it_acc <= step_acc;
        it_a   <= step_a;
        it_b   <= step_b;
        if (count == 5'd31) begin
          aluResult     <= iter_res;
          isBranchTaken <= 1'b0;
          branchPC      <= lat_bt;
        end
      end
    end
  end

endmodule

// File: tb/tb_ex_unit.sv
// Directed bench for ex_unit: a vector table run in order (flags carry between entries),
// then hand sequences for start-while-busy, output hold and reset during a divide.
module tb_ex_unit;

  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_SUB  = 5'b00001;
  localparam logic [4:0] OP_MUL  = 5'b00010;
  localparam logic [4:0] OP_DIV  = 5'b00011;
  localparam logic [4:0] OP_MOD  = 5'b00100;
  localparam logic [4:0] OP_CMP  = 5'b00101;
  localparam logic [4:0] OP_AND  = 5'b00110;
  localparam logic [4:0] OP_OR   = 5'b00111;
  localparam logic [4:0] OP_NOT  = 5'b01000;
  localparam logic [4:0] OP_MOV  = 5'b01001;
  localparam logic [4:0] OP_LSL  = 5'b01010;
  localparam logic [4:0] OP_LSR  = 5'b01011;
  localparam logic [4:0] OP_ASR  = 5'b01100;
  localparam logic [4:0] OP_LD   = 5'b01110;
  localparam logic [4:0] OP_ST   = 5'b01111;
  localparam logic [4:0] OP_BEQ  = 5'b10000;
  localparam logic [4:0] OP_BGT  = 5'b10001;
  localparam logic [4:0] OP_B    = 5'b10010;
  localparam logic [4:0] OP_CALL = 5'b10011;
  localparam logic [4:0] OP_RET  = 5'b10100;
  localparam logic [4:0] OP_UNU  = 5'b10110;

`ifdef EX_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif

  logic        clk = 1'b0;
  logic        reset, start;
  logic [5:0]  opcode_and_I;
  logic [31:0] op1, op2, immx, branchTarget;
  logic        busy, done, flagE, flagGT, isBranchTaken;
  logic [31:0] aluResult, branchPC;

  int checks = 0;
  int failures = 0;

  ex_unit dut (
    .clk(clk), .reset(reset), .start(start), .opcode_and_I(opcode_and_I),
    .op1(op1), .op2(op2), .immx(immx), .branchTarget(branchTarget),
    .busy(busy), .done(done), .aluResult(aluResult), .flagE(flagE), .flagGT(flagGT),
    .isBranchTaken(isBranchTaken), .branchPC(branchPC)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  op;
    logic        i;
    logic [31:0] a, b, imm, bt;
    logic [31:0] res;
    logic        e, gt, tk;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%h expected=0x%h", name, act, exp);
    end
  endtask

  // Launch one op once the unit is idle and return the number of edges until done is seen.
  // poke_at>0 pulses a competing start (with scrambled operands) that many edges after accept.
  task automatic issue(input logic [4:0] op, input logic i, input logic [31:0] a, b, imm, bt,
                       input int poke_at, output int lat);
    int guard = 0;
    @(negedge clk);
    while (busy && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    opcode_and_I = {op, i};
    op1 = a; op2 = b; immx = imm; branchTarget = bt;
    start = 1'b1;
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
      if (lat == 1) start = 1'b0;
      if (poke_at != 0 && lat == poke_at) begin
        opcode_and_I = {OP_ADD, 1'b0};
        op1 = 32'h1111_1111; op2 = 32'h2222_2222; immx = 32'h3333_3333;
        start = 1'b1;
      end
      if (poke_at != 0 && lat == poke_at + 1) start = 1'b0;
    end while (!done && lat < 60);
  endtask

  initial begin
    int lat;
    logic seen_done;
    logic [31:0] exp_pc;

    reset = 1'b1; start = 1'b0; opcode_and_I = '0;
    op1 = '0; op2 = '0; immx = '0; branchTarget = '0;

    vecs.push_back('{OP_ADD,  1'b1, 32'd7,        32'd0,        32'hFFFFFFFD, 32'h100, 32'd4,        1'b0, 1'b0, 1'b0, 1});
    vecs.push_back('{OP_CMP,  1'b0, 32'd5,        32'hFFFFFFFD, 32'd0,        32'h0,   32'd0,        1'b0, 1'b1, 1'b0, 1});
    vecs.push_back('{OP_BGT,  1'b0, 32'd0,        32'd0,        32'd0,        32'h40,  32'd0,        1'b0, 1'b1, 1'b1, 1});
    vecs.push_back('{OP_BEQ,  1'b0, 32'd0,        32'd0,        32'd0,        32'h40,  32'd0,        1'b0, 1'b1, 1'b0, 1});
    vecs.push_back('{OP_DIV,  1'b0, 32'hFFFFFFF9, 32'd2,        32'd0,        32'h0,   32'hFFFFFFFD, 1'b0, 1'b1, 1'b0, 33});
    vecs.push_back('{OP_MOD,  1'b0, 32'hFFFFFFF9, 32'd2,        32'd0,        32'h0,   32'hFFFFFFFF, 1'b0, 1'b1, 1'b0, 33});
    vecs.push_back('{OP_DIV,  1'b0, 32'd9,        32'd0,        32'd0,        32'h0,   32'd0,        1'b0, 1'b1, 1'b0, 33});
    vecs.push_back('{OP_MOD,  1'b0, 32'd9,        32'd0,        32'd0,        32'h0,   32'd9,        1'b0, 1'b1, 1'b0, 33});
    vecs.push_back('{OP_DIV,  1'b0, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h0,   32'h80000000, 1'b0, 1'b1, 1'b0, 33});
    vecs.push_back('{OP_MOD,  1'b0, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h0,   32'd0,        1'b0, 1'b1, 1'b0, 33});
    vecs.push_back('{OP_DIV,  1'b0, 32'd7,        32'hFFFFFFFE, 32'd0,        32'h0,   32'hFFFFFFFD, 1'b0, 1'b1, 1'b0, 33});
    vecs.push_back('{OP_MOD,  1'b0, 32'd7,        32'hFFFFFFFE, 32'd0,        32'h0,   32'd1,        1'b0, 1'b1, 1'b0, 33});
    vecs.push_back('{OP_MUL,  1'b0, 32'h10000,    32'h10001,    32'd0,        32'h0,   32'h00010000, 1'b0, 1'b1, 1'b0, MUL_LAT});
    vecs.push_back('{OP_MUL,  1'b1, 32'hFFFFFFFD, 32'd0,        32'd7,        32'h0,   32'hFFFFFFEB, 1'b0, 1'b1, 1'b0, MUL_LAT});
    vecs.push_back('{OP_RET,  1'b0, 32'h1234,     32'd0,        32'd0,        32'h999, 32'd0,        1'b0, 1'b1, 1'b1, 1});
    vecs.push_back('{OP_SUB,  1'b0, 32'd3,        32'd5,        32'd0,        32'h0,   32'hFFFFFFFE, 1'b0, 1'b1, 1'b0, 1});
    vecs.push_back('{OP_LSL,  1'b1, 32'd1,        32'd0,        32'h3F,       32'h0,   32'h80000000, 1'b0, 1'b1, 1'b0, 1});
    vecs.push_back('{OP_LSR,  1'b0, 32'h80000000, 32'd4,        32'd0,        32'h0,   32'h08000000, 1'b0, 1'b1, 1'b0, 1});
    vecs.push_back('{OP_ASR,  1'b0, 32'h80000000, 32'd4,        32'd0,        32'h0,   32'hF8000000, 1'b0, 1'b1, 1'b0, 1});
    vecs.push_back('{OP_AND,  1'b0, 32'hF0F0,     32'hFF00,     32'd0,        32'h0,   32'hF000,     1'b0, 1'b1, 1'b0, 1});
    vecs.push_back('{OP_OR,   1'b0, 32'hF0F0,     32'hFF00,     32'd0,        32'h0,   32'hFFF0,     1'b0, 1'b1, 1'b0, 1});
    vecs.push_back('{OP_NOT,  1'b0, 32'h5,        32'd0,        32'd0,        32'h0,   32'hFFFFFFFF, 1'b0, 1'b1, 1'b0, 1});
    vecs.push_back('{OP_MOV,  1'b1, 32'h5,        32'd1,        32'hCAFE0001, 32'h0,   32'hCAFE0001, 1'b0, 1'b1, 1'b0, 1});
    vecs.push_back('{OP_CMP,  1'b0, 32'hFFFFFFFF, 32'd1,        32'd0,        32'h0,   32'd0,        1'b0, 1'b0, 1'b0, 1});
    vecs.push_back('{OP_BGT,  1'b0, 32'd0,        32'd0,        32'd0,        32'h44,  32'd0,        1'b0, 1'b0, 1'b0, 1});
    vecs.push_back('{OP_B,    1'b0, 32'd0,        32'd0,        32'd0,        32'h48,  32'd0,        1'b0, 1'b0, 1'b1, 1});
    vecs.push_back('{OP_CALL, 1'b0, 32'd0,        32'd0,        32'd0,        32'h4C,  32'd0,        1'b0, 1'b0, 1'b1, 1});
    vecs.push_back('{OP_CMP,  1'b1, 32'd8,        32'd3,        32'd8,        32'h0,   32'd0,        1'b1, 1'b0, 1'b0, 1});
    vecs.push_back('{OP_BEQ,  1'b0, 32'd0,        32'd0,        32'd0,        32'h80,  32'd0,        1'b1, 1'b0, 1'b1, 1});
    vecs.push_back('{OP_UNU,  1'b0, 32'd5,        32'd6,        32'd0,        32'h0,   32'd0,        1'b1, 1'b0, 1'b0, 1});
    vecs.push_back('{OP_ST,   1'b1, 32'h100,      32'd8,        32'd4,        32'h0,   32'h104,      1'b1, 1'b0, 1'b0, 1});
    vecs.push_back('{OP_LD,   1'b0, 32'h100,      32'd8,        32'd4,        32'h0,   32'h108,      1'b1, 1'b0, 1'b0, 1});

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_alu", aluResult, 32'd0);
    chk("rst_flags", {30'd0, flagE, flagGT}, 32'd0);
    chk("rst_taken", {31'd0, isBranchTaken}, 32'd0);
    chk("rst_pc", branchPC, 32'd0);

    foreach (vecs[k]) begin
      issue(vecs[k].op, vecs[k].i, vecs[k].a, vecs[k].b, vecs[k].imm, vecs[k].bt, 0, lat);
      exp_pc = (vecs[k].op == OP_RET) ? vecs[k].a : vecs[k].bt;
      chk($sformatf("v%0d_lat", k), lat, vecs[k].lat);
      chk($sformatf("v%0d_res", k), aluResult, vecs[k].res);
      chk($sformatf("v%0d_flagE", k), {31'd0, flagE}, {31'd0, vecs[k].e});
      chk($sformatf("v%0d_flagGT", k), {31'd0, flagGT}, {31'd0, vecs[k].gt});
      chk($sformatf("v%0d_taken", k), {31'd0, isBranchTaken}, {31'd0, vecs[k].tk});
      chk($sformatf("v%0d_pc", k), branchPC, exp_pc);
    end

    // Divide with a competing start five edges in: must be ignored, not queued.
    issue(OP_DIV, 1'b0, 32'hFFFFFFF9, 32'd2, 32'd0, 32'h200, 5, lat);
    chk("poke_lat", lat, 33);
    chk("poke_res", aluResult, 32'hFFFFFFFD);
    chk("poke_pc", branchPC, 32'h200);
    seen_done = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (done || busy) seen_done = 1'b1;
    end
    chk("poke_no_queue", {31'd0, seen_done}, 32'd0);
    chk("hold_res", aluResult, 32'hFFFFFFFD);
    chk("hold_flags", {30'd0, flagE, flagGT}, 32'h2);

    // Reset during a divide at N+10.
    @(negedge clk);
    opcode_and_I = {OP_DIV, 1'b0};
    op1 = 32'd100; op2 = 32'd7; branchTarget = 32'h300;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (9) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    chk("midrst_alu", aluResult, 32'd0);
    chk("midrst_flags", {30'd0, flagE, flagGT}, 32'd0);
    chk("midrst_pc", branchPC, 32'd0);
    seen_done = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done) seen_done = 1'b1;
    end
    chk("midrst_no_done", {31'd0, seen_done}, 32'd0);

    issue(OP_ADD, 1'b0, 32'd2, 32'd3, 32'd0, 32'h10, 0, lat);
    chk("post_lat", lat, 1);
    chk("post_res", aluResult, 32'd5);
    chk("post_flags", {30'd0, flagE, flagGT}, 32'd0);
    chk("post_pc", branchPC, 32'h10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
